// File: rtl/hall_supervisor.sv
// hall_supervisor: sequences a hall-sensor front end through reset, settle
// and run phases, measures commutation period and direction, and retries
// a bounded number of times on sensor faults before latching a fault.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | sensor held in reset, waiting for enable
// RESET_HOLD | sensor reset asserted for RST_CYC cycles
// SETTLE     | sensor released, status ignored for SETTLE_CYC cycles
// RUN        | step tracking, period measurement, fault detection
// FAULT      | retries exhausted; sensor held in reset until clear/disable
module hall_supervisor #(
  parameter int CNT_W      = 24,
  parameter int RST_CYC    = 16,
  parameter int SETTLE_CYC = 1024,
  parameter int RETRY_MAX  = 3
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_enable,
  input  logic             I_clear,
  input  logic [CNT_W-1:0] I_timeout,
  input  logic [2:0]       I_hall_step,
  input  logic             I_hall_error,
  input  logic             I_hall_lost,
  output logic             O_hall_rst,
  output logic [2:0]       O_state,
  output logic             O_step_evt,
  output logic [CNT_W-1:0] O_period,
  output logic             O_valid,
  output logic             O_dir,
  output logic             O_fault,
  output logic [1:0]       O_fault_code,
  output logic [1:0]       O_retry_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RESET_HOLD = 3'd1,
    ST_SETTLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  // Timer reload values: the down-counter runs load..0, so a phase lasts load+1 cycles.
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [1:0]       RETRY_LIM   = 2'(RETRY_MAX);

  localparam logic [1:0] CODE_LOST  = 2'b01;
  localparam logic [1:0] CODE_ERROR = 2'b10;
  localparam logic [1:0] CODE_SEQ   = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] tmr_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic [2:0]       ref_step;
  logic             evt_seen;

  logic [2:0]       step_fwd;
  logic [2:0]       step_bwd;
  logic             step_illegal;
  logic             step_changed;
  logic             legal_fwd;
  logic             legal_bwd;
  logic             seq_err;
  logic             run_fault;
  logic [1:0]       fault_code_nxt;
  logic             stall;
  logic [CNT_W-1:0] period_inc;
  logic             retry_left;

  assign O_state = state;

  // Step-change classification, stall detection and fault priority for RUN.
  always_comb begin
    step_fwd       = (ref_step == 3'd5) ? 3'd0 : ref_step + 3'd1;
    step_bwd       = (ref_step == 3'd0) ? 3'd5 : ref_step - 3'd1;
    step_illegal   = (I_hall_step > 3'd5);
    step_changed   = (I_hall_step != ref_step);
    legal_fwd      = !step_illegal && (I_hall_step == step_fwd);
    legal_bwd      = !step_illegal && (I_hall_step == step_bwd);
    // An illegal code is a sequence fault even if it equals the reference.
    seq_err        = step_illegal || (step_changed && !legal_fwd && !legal_bwd);
    run_fault      = I_hall_lost || I_hall_error || seq_err;
    fault_code_nxt = CODE_SEQ;
    if (I_hall_lost) begin
      fault_code_nxt = CODE_LOST;
    end else if (I_hall_error) begin
      fault_code_nxt = CODE_ERROR;
    end
    // Timeout is compared live so a new threshold applies immediately.
    stall          = (I_timeout != '0) && (period_cnt >= I_timeout);
    period_inc     = (period_cnt == '1) ? period_cnt : period_cnt + CNT_W'(1);
    retry_left     = (O_retry_cnt < RETRY_LIM);
  end

  // Supervisor FSM with registered outputs, timer and period counter.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state        <= ST_IDLE;
      tmr_cnt      <= '0;
      period_cnt   <= '0;
      ref_step     <= '0;
      evt_seen     <= 1'b0;
      O_hall_rst   <= 1'b1;
      O_step_evt   <= 1'b0;
      O_period     <= '0;
      O_valid      <= 1'b0;
      O_dir        <= 1'b0;
      O_fault      <= 1'b0;
      O_fault_code <= '0;
      O_retry_cnt  <= '0;
    end else begin
      O_step_evt <= 1'b0;
      if (!I_enable) begin
        // Disable overrides everything; leaving FAULT also drops the fault record.
        state      <= ST_IDLE;
        tmr_cnt    <= '0;
        period_cnt <= '0;
        evt_seen   <= 1'b0;
        O_hall_rst <= 1'b1;
        O_valid    <= 1'b0;
        if (state == ST_FAULT) begin
          O_fault      <= 1'b0;
          O_fault_code <= '0;
          O_retry_cnt  <= '0;
        end
      end else begin
        // Outside FAULT a clear only forgets earlier retries; a fault in the
        // same RUN cycle below still takes effect.
        if (I_clear && (state != ST_FAULT)) begin
          O_retry_cnt <= '0;
        end
        case (state)
          ST_IDLE: begin
            state      <= ST_RESET_HOLD;
            tmr_cnt    <= RST_LOAD;
            O_hall_rst <= 1'b1;
          end
          ST_RESET_HOLD: begin
            if (tmr_cnt == '0) begin
              state      <= ST_SETTLE;
              tmr_cnt    <= SETTLE_LOAD;
              O_hall_rst <= 1'b0;
            end else begin
              tmr_cnt <= tmr_cnt - CNT_W'(1);
            end
          end
          ST_SETTLE: begin
            if (tmr_cnt == '0) begin
              state      <= ST_RUN;
              ref_step   <= I_hall_step;
              period_cnt <= CNT_W'(1);
              evt_seen   <= 1'b0;
              O_valid    <= 1'b0;
            end else begin
              tmr_cnt <= tmr_cnt - CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (run_fault) begin
              O_valid  <= 1'b0;
              evt_seen <= 1'b0;
              if (retry_left) begin
                O_retry_cnt <= O_retry_cnt + 2'd1;
                state       <= ST_RESET_HOLD;
                tmr_cnt     <= RST_LOAD;
                O_hall_rst  <= 1'b1;
              end else begin
                state        <= ST_FAULT;
                O_fault      <= 1'b1;
                O_fault_code <= fault_code_nxt;
                O_hall_rst   <= 1'b1;
              end
            end else if (step_changed) begin
              // Only legal neighbours reach here; the period needs two events to be valid.
              O_step_evt <= 1'b1;
              O_dir      <= legal_fwd;
              ref_step   <= I_hall_step;
              O_period   <= period_cnt;
              period_cnt <= CNT_W'(1);
              O_valid    <= evt_seen;
              evt_seen   <= 1'b1;
            end else if (stall) begin
              O_valid    <= 1'b0;
              O_period   <= '1;
              evt_seen   <= 1'b0;
              period_cnt <= period_inc;
            end else begin
              period_cnt <= period_inc;
            end
          end
          ST_FAULT: begin
            O_hall_rst <= 1'b1;
            if (I_clear) begin
              state        <= ST_IDLE;
              O_fault      <= 1'b0;
              O_fault_code <= '0;
              O_retry_cnt  <= '0;
            end
          end
          default: begin
            state      <= ST_IDLE;
            O_hall_rst <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hall_supervisor.sv
// Directed testbench for hall_supervisor with default parameters.
`timescale 1ns/1ps
module tb_hall_supervisor;

  localparam int CNT_W = 24;

  logic             I_clk = 1'b0;
  logic             I_rst_n;
  logic             I_enable;
  logic             I_clear;
  logic [CNT_W-1:0] I_timeout;
  logic [2:0]       I_hall_step;
  logic             I_hall_error;
  logic             I_hall_lost;
  logic             O_hall_rst;
  logic [2:0]       O_state;
  logic             O_step_evt;
  logic [CNT_W-1:0] O_period;
  logic             O_valid;
  logic             O_dir;
  logic             O_fault;
  logic [1:0]       O_fault_code;
  logic [1:0]       O_retry_cnt;

  int n_tests   = 0;
  int n_fail    = 0;
  int evt_total = 0;
  int n;
  int ev0;

  hall_supervisor dut (
    .I_clk        (I_clk),
    .I_rst_n      (I_rst_n),
    .I_enable     (I_enable),
    .I_clear      (I_clear),
    .I_timeout    (I_timeout),
    .I_hall_step  (I_hall_step),
    .I_hall_error (I_hall_error),
    .I_hall_lost  (I_hall_lost),
    .O_hall_rst   (O_hall_rst),
    .O_state      (O_state),
    .O_step_evt   (O_step_evt),
    .O_period     (O_period),
    .O_valid      (O_valid),
    .O_dir        (O_dir),
    .O_fault      (O_fault),
    .O_fault_code (O_fault_code),
    .O_retry_cnt  (O_retry_cnt)
  );

  always #5 I_clk = ~I_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk);
    #1;
    if (O_step_evt === 1'b1) evt_total++;
  endtask

  task automatic ticks(input int cnt);
    for (int i = 0; i < cnt; i++) tick();
  endtask

  task automatic wait_state(input logic [2:0] st, input int max, output int cnt);
    cnt = 0;
    while (O_state !== st && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  task automatic dwell(input logic [2:0] st, input int max, output int cnt);
    cnt = 0;
    while (O_state === st && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    I_rst_n = 1'b0; I_enable = 1'b0; I_clear = 1'b0; I_timeout = '0;
    I_hall_step = 3'd0; I_hall_error = 1'b0; I_hall_lost = 1'b0;
    #23;
    check("rst_state",    O_state, 3'd0);
    check("rst_hall_rst", O_hall_rst, 1'b1);
    check("rst_period",   O_period, 0);
    check("rst_valid",    O_valid, 1'b0);
    check("rst_dir",      O_dir, 1'b0);
    check("rst_evt",      O_step_evt, 1'b0);
    check("rst_fault",    O_fault, 1'b0);
    check("rst_retry",    O_retry_cnt, 2'd0);
    tick();
    I_rst_n = 1'b1;
    ticks(2);
    check("idle_no_enable", O_state, 3'd0);

    // Startup sequence and forward stepping at 1000-cycle spacing
    I_enable = 1'b1;
    tick();
    check("enter_reset_hold", O_state, 3'd1);
    check("hold_hall_rst", O_hall_rst, 1'b1);
    dwell(3'd1, 100, n);
    check("reset_hold_len", n, 16);
    check("settle_hall_rst", O_hall_rst, 1'b0);
    dwell(3'd2, 2000, n);
    check("settle_len", n, 1024);
    check("run_entered", O_state, 3'd3);
    ticks(999);
    I_hall_step = 3'd1;
    tick();
    check("first_evt", O_step_evt, 1'b1);
    check("first_valid", O_valid, 1'b0);
    check("first_period", O_period, 1000);
    check("first_dir", O_dir, 1'b1);
    ticks(999);
    I_hall_step = 3'd2;
    tick();
    check("second_evt", O_step_evt, 1'b1);
    check("second_period", O_period, 1000);
    check("second_valid", O_valid, 1'b1);
    check("second_dir", O_dir, 1'b1);
    tick();
    check("evt_one_cycle", O_step_evt, 1'b0);

    // Reverse stepping at 500-cycle spacing
    I_hall_step = 3'd3;
    tick();
    ev0 = evt_total;
    ticks(499);
    I_hall_step = 3'd2;
    tick();
    check("rev1_dir", O_dir, 1'b0);
    check("rev1_period", O_period, 500);
    check("rev1_valid", O_valid, 1'b1);
    ticks(499);
    I_hall_step = 3'd1;
    tick();
    check("rev2_dir", O_dir, 1'b0);
    check("rev2_period", O_period, 500);
    check("rev_evt_count", evt_total - ev0, 2);

    // Stall detection, then the two-event valid rule restarts
    I_timeout = 24'd2000;
    ticks(1999);
    check("pre_stall_valid", O_valid, 1'b1);
    tick();
    check("stall_valid", O_valid, 1'b0);
    check("stall_period", O_period, 32'h00FF_FFFF);
    check("stall_state", O_state, 3'd3);
    check("stall_no_fault", O_fault, 1'b0);
    I_timeout = '0;
    I_hall_step = 3'd2;
    tick();
    check("post_stall_evt", O_step_evt, 1'b1);
    check("post_stall_valid", O_valid, 1'b0);
    check("post_stall_period", O_period, 2001);
    ticks(299);
    I_hall_step = 3'd3;
    tick();
    check("post_stall2_valid", O_valid, 1'b1);
    check("post_stall2_period", O_period, 300);

    // Sequence faults: three retries, then latched fault
    I_hall_step = 3'd2; tick();
    I_hall_step = 3'd1; tick();
    I_hall_step = 3'd4; tick();
    check("seq1_retry", O_retry_cnt, 2'd1);
    check("seq1_state", O_state, 3'd1);
    check("seq1_valid", O_valid, 1'b0);
    I_hall_step = 3'd1;
    wait_state(3'd3, 2000, n);
    check("seq2_run", O_state, 3'd3);
    I_hall_step = 3'd4; tick();
    check("seq2_retry", O_retry_cnt, 2'd2);
    I_hall_step = 3'd1;
    wait_state(3'd3, 2000, n);
    I_hall_step = 3'd4; tick();
    check("seq3_retry", O_retry_cnt, 2'd3);
    check("seq3_state", O_state, 3'd1);
    I_hall_step = 3'd1;
    wait_state(3'd3, 2000, n);
    I_hall_step = 3'd4; tick();
    check("seq4_state", O_state, 3'd4);
    check("seq4_fault", O_fault, 1'b1);
    check("seq4_code", O_fault_code, 2'b11);
    check("seq4_hall_rst", O_hall_rst, 1'b1);
    ticks(5);
    check("fault_sticky", O_state, 3'd4);
    I_clear = 1'b1; tick(); I_clear = 1'b0;
    check("clear_state", O_state, 3'd0);
    check("clear_fault", O_fault, 1'b0);
    check("clear_code", O_fault_code, 2'b00);
    check("clear_retry", O_retry_cnt, 2'd0);

    // Lost ignored during SETTLE; lost+error in RUN reports lost
    I_hall_step = 3'd0;
    wait_state(3'd2, 100, n);
    I_hall_lost = 1'b1;
    ticks(100);
    check("settle_lost_state", O_state, 3'd2);
    check("settle_lost_retry", O_retry_cnt, 2'd0);
    I_hall_lost = 1'b0;
    wait_state(3'd3, 2000, n);
    check("lost_run", O_state, 3'd3);
    I_hall_lost = 1'b1; I_hall_error = 1'b1;
    tick();
    check("lost1_retry", O_retry_cnt, 2'd1);
    wait_state(3'd4, 6000, n);
    check("lost_fault_state", O_state, 3'd4);
    check("lost_fault_code", O_fault_code, 2'b01);
    check("lost_fault_retry", O_retry_cnt, 2'd3);
    I_enable = 1'b0; I_hall_lost = 1'b0; I_hall_error = 1'b0;
    tick();
    check("disable_state", O_state, 3'd0);
    check("disable_fault", O_fault, 1'b0);
    check("disable_code", O_fault_code, 2'b00);
    check("disable_retry", O_retry_cnt, 2'd0);

    // Clear outside FAULT, then asynchronous reset mid-RUN
    I_enable = 1'b1; I_hall_step = 3'd0;
    wait_state(3'd3, 2000, n);
    I_hall_step = 3'd3; tick();
    check("jump_retry", O_retry_cnt, 2'd1);
    wait_state(3'd3, 2000, n);
    I_clear = 1'b1; tick(); I_clear = 1'b0;
    check("run_clear_retry", O_retry_cnt, 2'd0);
    check("run_clear_state", O_state, 3'd3);
    ticks(8);
    I_hall_step = 3'd4; tick();
    check("pre_rst_period", O_period, 10);
    ticks(19);
    I_hall_step = 3'd5; tick();
    check("pre_rst_valid", O_valid, 1'b1);
    #3;
    I_rst_n = 1'b0;
    #1;
    check("async_state", O_state, 3'd0);
    check("async_hall_rst", O_hall_rst, 1'b1);
    check("async_evt", O_step_evt, 1'b0);
    check("async_period", O_period, 0);
    check("async_valid", O_valid, 1'b0);
    check("async_dir", O_dir, 1'b0);
    tick();
    I_rst_n = 1'b1;
    check("post_rst_idle", O_state, 3'd0);
    tick();
    check("post_rst_start", O_state, 3'd1);
    wait_state(3'd2, 100, n);
    ticks(10);
    I_enable = 1'b0;
    tick();
    check("settle_disable_state", O_state, 3'd0);
    check("settle_disable_hall_rst", O_hall_rst, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hall_supervisor.md
HALL_SUPERVISOR -- requirements
Module: hall_supervisor

Interface
REQ-001 SHALL have parameter CNT_W, default 24, width of period/timeout counters.
REQ-002 SHALL have parameter RST_CYC, default 16, cycles O_hall_rst is held high per (re)start.
REQ-003 SHALL have parameter SETTLE_CYC, default 1024, post-reset cycles during which hall status is ignored.
REQ-004 SHALL have parameter RETRY_MAX, default 3, automatic restarts allowed before latched fault.
REQ-005 I_clk  in  1  single clock for all logic (hall sensor clock domain).
REQ-006 I_rst_n  in  1  asynchronous, active-low reset.
REQ-007 I_enable  in  1  level; 1 = supervise and run hall sensor, 0 = idle.
REQ-008 I_clear  in  1  single-cycle pulse; clears latched fault.
REQ-009 I_timeout  in  CNT_W  stall threshold in cycles; 0 disables stall detection.
REQ-010 I_hall_step  in  3  commutation step from hall sensor; legal values 0..5.
REQ-011 I_hall_error, I_hall_lost  in  1 each  status flags from hall sensor.
REQ-012 O_hall_rst  out  1  active-high reset driven to hall sensor.
REQ-013 O_state  out  3  IDLE=0, RESET_HOLD=1, SETTLE=2, RUN=3, FAULT=4.
REQ-014 O_step_evt  out  1  one-cycle pulse per legal step change in RUN.
REQ-015 O_period  out  CNT_W  cycles between last two step changes.
REQ-016 O_valid, O_dir  out  1 each  period valid; direction (1 = step+1 mod 6).
REQ-017 O_fault  out  1; O_fault_code  out  2 (01 lost, 10 error, 11 sequence); O_retry_cnt  out  2.

Function
REQ-018 Any state, I_enable=0 SHALL force IDLE next cycle; priority over all other transitions.
REQ-019 IDLE: O_hall_rst=1; I_enable=1 SHALL go to RESET_HOLD next cycle.
REQ-020 RESET_HOLD: O_hall_rst=1 for exactly RST_CYC cycles, then SETTLE.
REQ-021 SETTLE: O_hall_rst=0; I_hall_error/I_hall_lost/step changes SHALL be ignored for SETTLE_CYC cycles, then RUN with I_hall_step captured as reference step and period counter=1.
REQ-022 RUN: period counter SHALL increment each cycle, saturating at all-ones.
REQ-023 RUN step change (I_hall_step != reference) to reference+1 mod 6 or reference-1 mod 6: O_step_evt=1, O_dir set accordingly, reference updated, O_period<=counter, counter<=1.
REQ-024 First legal change after entering RUN SHALL NOT set O_valid; second and later SHALL set O_valid=1.
REQ-025 Stall: I_timeout!=0 and counter>=I_timeout with no change that cycle: O_valid<=0, O_period<=all-ones, state stays RUN, no fault; next legal change restarts the two-event valid rule.
REQ-026 Step change and stall in same cycle: step change wins.
REQ-027 RUN fault SHALL be any of: I_hall_lost=1, I_hall_error=1, illegal step (6/7), or change by other than +/-1 mod 6; code priority lost > error > sequence.
REQ-028 On fault with O_retry_cnt<RETRY_MAX: O_retry_cnt++, O_valid<=0, state RESET_HOLD.
REQ-029 On fault with O_retry_cnt=RETRY_MAX: state FAULT, O_fault=1, O_fault_code latched, O_hall_rst=1.
REQ-030 FAULT SHALL exit only via I_clear (->IDLE) or I_enable=0 (->IDLE); both clear O_fault, O_fault_code, O_retry_cnt.
REQ-031 I_clear outside FAULT SHALL clear O_retry_cnt only.
REQ-032 I_timeout changes SHALL take effect the cycle they are presented.

Reset
REQ-033 I_rst_n=0 SHALL asynchronously set: state IDLE, O_hall_rst=1, O_step_evt=0, O_period=0, O_valid=0, O_dir=0, O_fault=0, O_fault_code=0, O_retry_cnt=0, all counters 0.
REQ-034 Reset asserted mid-operation SHALL abort any state; after release block stays IDLE until I_enable=1 observed.

Verification
REQ-035 Enable, steps 0->1->2 every 1000 cycles after RUN -> O_hall_rst high 16 cycles, RUN at +1040, second change O_period=1000, O_valid=1, O_dir=1.
REQ-036 In RUN, steps 3->2->1 every 500 cycles -> O_dir=0, O_period=500, one O_step_evt per change.
REQ-037 I_timeout=2000, no change -> at counter 2000 O_valid=0, O_period=0xFFFFFF, O_state=3.
REQ-038 Step 1->4 four times (re-entering RUN each time) -> O_retry_cnt 1,2,3 then O_state=4, O_fault=1, O_fault_code=11; I_clear -> IDLE, all fault fields 0.
REQ-039 I_hall_lost=1 during SETTLE -> ignored; asserted in RUN together with I_hall_error -> O_fault_code=01 on final fault.
REQ-040 I_rst_n low mid-RUN -> all outputs at REQ-033 values same cycle; I_enable=0 mid-SETTLE -> IDLE next cycle.
